hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 132 +++++++++++++
 tb/tb_hazard_controller.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, taken-branch flush and
// multi-cycle (mul/div) wait with timeout detection.
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating 16-bit
// stall/flush performance counters (StallCnt_o, FlushCnt_o).
module hazard_controller #(
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [4:0] ID_RS1_i,
  input  logic [4:0] ID_RS2_i,
  input  logic       ID_UsesRS2_i,
  input  logic       EX_MemRead_i,
  input  logic [4:0] EX_RD_i,
  input  logic       Branch_Taken_i,
  input  logic       MC_Start_i,
  input  logic       MC_Done_i,
  output logic       PC_Write_o,
  output logic       IFID_Write_o,
  output logic       IDEX_Write_o,
  output logic       IDEX_Bubble_o,
  output logic       EXMEM_Bubble_o,
  output logic       IFID_Flush_o,
  output logic       MC_Err_o,
  output logic       State_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] StallCnt_o,
  output logic [15:0] FlushCnt_o
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(MC_TIMEOUT - 1);

  state_t     state, state_next;
  logic [7:0] wait_cnt, wait_cnt_next;
  logic       err, err_next;
  logic       load_use;

  assign load_use = EX_MemRead_i && (EX_RD_i != 5'd0) &&
                    ((EX_RD_i == ID_RS1_i) || (ID_UsesRS2_i && (EX_RD_i == ID_RS2_i)));

  // State, wait counter and sticky error register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= RUN;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      err      <= err_next;
    end
  end

  // Next-state logic and pipeline control outputs
  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    err_next       = err;
    PC_Write_o     = 1'b1;
    IFID_Write_o   = 1'b1;
    IDEX_Write_o   = 1'b1;
    IDEX_Bubble_o  = 1'b0;
    EXMEM_Bubble_o = 1'b0;
    IFID_Flush_o   = 1'b0;
    case (state)
      RUN: begin
        // A multi-cycle op and a load cannot share EX, so the order of
        // these two checks never matters in practice.
        if (MC_Start_i && !MC_Done_i) begin
          PC_Write_o     = 1'b0;
          IFID_Write_o   = 1'b0;
          IDEX_Write_o   = 1'b0;
          EXMEM_Bubble_o = 1'b1;
          state_next     = MC_WAIT;
          wait_cnt_next  = '0;
        end else if (load_use) begin
          PC_Write_o    = 1'b0;
          IFID_Write_o  = 1'b0;
          IDEX_Bubble_o = 1'b1;
        end else if (Branch_Taken_i) begin
          IFID_Flush_o = 1'b1;
        end
      end
      MC_WAIT: begin
        if (MC_Done_i) begin
          state_next = RUN;
        end else begin
          PC_Write_o     = 1'b0;
          IFID_Write_o   = 1'b0;
          IDEX_Write_o   = 1'b0;
          EXMEM_Bubble_o = 1'b1;
          if (wait_cnt == LAST_WAIT) begin
            err_next   = 1'b1;
            state_next = RUN;
          end else begin
            wait_cnt_next = wait_cnt + 8'd1;
          end
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign MC_Err_o = err;
  assign State_o  = (state == MC_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;

  // Saturating counts of stalled and flushed cycles
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_Write_o && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
      if (IFID_Flush_o && (flush_cnt != '1)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign StallCnt_o = stall_cnt;
  assign FlushCnt_o = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller (MC_TIMEOUT = 4).
module tb_hazard_controller;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses2;
    logic       memrd;
    logic [4:0] rd;
    logic       br;
    logic       start;
    logic       done;
  } stim_t;

  // {pc, ifid, idex_w, idex_bub, exmem_bub, flush, err, state}
  localparam logic [7:0] RUN_OK = 8'b1110_0000;
  localparam logic [7:0] LU_ST  = 8'b0011_0000;
  localparam logic [7:0] MC_ST  = 8'b0000_1000;
  localparam logic [7:0] FLUSH  = 8'b1110_0100;
  localparam logic [7:0] ST     = 8'b0000_0001;
  localparam logic [7:0] ER     = 8'b0000_0010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       uses2, memrd, br, start, done;
  logic       pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble;
  logic       ifid_flush, mc_err, state;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] cnt_q[$];

  always #5 clk = ~clk;

  hazard_controller #(.MC_TIMEOUT(4)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .ID_RS1_i      (rs1),
    .ID_RS2_i      (rs2),
    .ID_UsesRS2_i  (uses2),
    .EX_MemRead_i  (memrd),
    .EX_RD_i       (rd),
    .Branch_Taken_i(br),
    .MC_Start_i    (start),
    .MC_Done_i     (done),
    .PC_Write_o    (pc_write),
    .IFID_Write_o  (ifid_write),
    .IDEX_Write_o  (idex_write),
    .IDEX_Bubble_o (idex_bubble),
    .EXMEM_Bubble_o(exmem_bubble),
    .IFID_Flush_o  (ifid_flush),
    .MC_Err_o      (mc_err),
    .State_o       (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt_o    (stall_cnt),
    .FlushCnt_o    (flush_cnt)
`endif
  );

  function automatic logic [7:0] outs();
    return {pc_write, ifid_write, idex_write, idex_bubble, exmem_bubble,
            ifid_flush, mc_err, state};
  endfunction

  function automatic stim_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic u2,
                               input logic mr, input logic [4:0] d, input logic b,
                               input logic s, input logic dn);
    stim_t x;
    x.rs1 = r1; x.rs2 = r2; x.uses2 = u2; x.memrd = mr;
    x.rd = d; x.br = b; x.start = s; x.done = dn;
    return x;
  endfunction

  task automatic apply(input stim_t s);
    rs1 = s.rs1; rs2 = s.rs2; uses2 = s.uses2; memrd = s.memrd;
    rd = s.rd; br = s.br; start = s.start; done = s.done;
  endtask

  task automatic test_reset();
    logic [7:0] got, e;
    rst_n = 1'b0;
    apply('0);
    exp_q.push_back(RUN_OK);
    #3;
    got = outs();
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL reset_state: got %b required %b", got, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t st[10];
    logic [7:0] ex[10];
    logic [7:0] got, e;
    st[0] = mk(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0); ex[0] = LU_ST;
    st[1] = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); ex[1] = RUN_OK;
    st[2] = mk(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); ex[2] = RUN_OK;
    st[3] = mk(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); ex[3] = LU_ST;
    st[4] = mk(5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0); ex[4] = LU_ST;
    st[5] = mk(5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); ex[5] = FLUSH;
    st[6] = mk(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0); ex[6] = RUN_OK;
    st[7] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); ex[7] = RUN_OK;
    st[8] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); ex[8] = RUN_OK;
    st[9] = '0;                                                  ex[9] = RUN_OK;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = outs();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL load_use[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_mc_wait();
    stim_t st[7];
    logic [7:0] ex[7];
    logic [7:0] got, e;
    st[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); ex[0] = MC_ST;
    st[1] = '0;                                                  ex[1] = MC_ST | ST;
    st[2] = mk(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0); ex[2] = MC_ST | ST;
    st[3] = '0;                                                  ex[3] = MC_ST | ST;
    st[4] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); ex[4] = RUN_OK | ST;
    st[5] = '0;                                                  ex[5] = RUN_OK;
    st[6] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); ex[6] = FLUSH;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = outs();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL mc_wait[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

  task automatic test_timeout();
    stim_t st[8];
    logic [7:0] ex[8];
    logic [7:0] got, e;
    st[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); ex[0] = MC_ST;
    for (int i = 1; i < 5; i++) begin
      st[i] = '0; ex[i] = MC_ST | ST;
    end
    st[5] = '0;                                                  ex[5] = RUN_OK | ER;
    st[6] = mk(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0); ex[6] = LU_ST | ER;
    st[7] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); ex[7] = RUN_OK | ER;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = outs();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL timeout[%0d]: got %b required %b", i, got, e);
      end
    end
    // error flag must clear on reset alone, without a clock edge
    @(posedge clk); #1;
    apply('0);
    rst_n = 1'b0;
    exp_q.push_back(RUN_OK);
    #1;
    got = outs();
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL timeout_reset: got %b required %b", got, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    stim_t st[4];
    logic [7:0] ex[4];
    logic [7:0] got, e;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, (i == 0), 1'b0));
      exp_q.push_back(i == 0 ? MC_ST : (MC_ST | ST));
      @(negedge clk);
      got = outs();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL mid_wait_pre[%0d]: got %b required %b", i, got, e);
      end
    end
    // second MC_WAIT cycle: confirm still waiting, then reset asynchronously
    @(posedge clk); #1;
    exp_q.push_back(MC_ST | ST);
    #1;
    got = outs();
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL mid_wait_second: got %b required %b", got, e);
    end
    rst_n = 1'b0;
    exp_q.push_back(RUN_OK);
    #1;
    got = outs();
    e = exp_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL mid_wait_async_reset: got %b required %b", got, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
    st[0] = '0;                                                  ex[0] = RUN_OK;
    st[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); ex[1] = MC_ST;
    st[2] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); ex[2] = RUN_OK | ST;
    st[3] = '0;                                                  ex[3] = RUN_OK;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(negedge clk);
      got = outs();
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_err++;
        $display("FAIL after_reset[%0d]: got %b required %b", i, got, e);
      end
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [31:0] got, e;
    @(negedge clk);
    rst_n = 1'b0;
    apply('0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      apply(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0));
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      apply(mk(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    apply('0);
    cnt_q.push_back({16'd2, 16'd3});
    @(negedge clk);
    got = {stall_cnt, flush_cnt};
    e = cnt_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL perf_small: got %h required %h", got, e);
    end
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk); #1;
      apply(mk(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    apply('0);
    cnt_q.push_back({16'hFFFF, 16'd3});
    @(negedge clk);
    got = {stall_cnt, flush_cnt};
    e = cnt_q.pop_front();
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL perf_saturate: got %h required %h", got, e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_mc_wait();
    test_timeout();
    test_reset_mid_wait();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
